// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: scans one voice per cycle to pick a retrigger,
// free or stolen voice for note-on events, and releases matching voices on note-off.
module voice_alloc #(
  parameter int VOICES  = 8,
  parameter int V_WIDTH = 3
) (
  input  logic               OSC_CLK,
  input  logic               iRST_N,
  input  logic               ev_valid,
  output logic               ev_ready,
  input  logic               ev_on,
  input  logic [6:0]         ev_key,
  input  logic [7:0]         ev_vel,
  input  logic               all_off,
  input  logic [VOICES-1:0]  voice_free,
  output logic [VOICES-1:0]  keys_on,
  output logic               note_on,
  output logic [V_WIDTH-1:0] cur_key_adr,
  output logic [7:0]         cur_key_val,
  output logic [7:0]         cur_vel_on,
  output logic [7:0]         cur_vel_off,
  output logic               steal
);

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

  localparam logic [V_WIDTH-1:0] LAST = V_WIDTH'(VOICES - 1);

  state_t             state;
  logic               lat_on;
  logic [6:0]         lat_key;
  logic [7:0]         lat_vel;
  logic [V_WIDTH-1:0] scan_idx;
  logic [V_WIDTH-1:0] steal_ptr;
  logic               match_hit;
  logic [V_WIDTH-1:0] match_idx;
  logic               free_hit;
  logic [V_WIDTH-1:0] free_idx;
  logic [6:0]         key_tab [VOICES];

  logic [V_WIDTH-1:0] on_target;
  logic               on_steal;

  assign ev_ready = (state == IDLE);

  // Note-on target: retrigger beats a free voice, which beats stealing.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    on_target = steal_ptr;
    on_steal  = 1'b0;
    if (match_hit) begin
      on_target = match_idx;
    end else if (free_hit) begin
      on_target = free_idx;
    end else begin
      on_steal = 1'b1;
    end
  end

  always_ff @(posedge OSC_CLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state       <= IDLE;
      lat_on      <= 1'b0;
      lat_key     <= '0;
      lat_vel     <= '0;
      scan_idx    <= '0;
      steal_ptr   <= '0;
      match_hit   <= 1'b0;
      match_idx   <= '0;
      free_hit    <= 1'b0;
      free_idx    <= '0;
      keys_on     <= '0;
      note_on     <= 1'b0;
      steal       <= 1'b0;
      cur_key_adr <= '0;
      cur_key_val <= '0;
      cur_vel_on  <= '0;
      cur_vel_off <= '0;
      // NOTE: the key table is small and must read as zero after reset, so it is
      // reset as flops rather than inferred as a RAM.
      for (int i = 0; i < VOICES; i++) key_tab[i] <= '0;
    end else begin
      note_on <= 1'b0;
      steal   <= 1'b0;
      if (all_off) begin
        keys_on <= '0;
        state   <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (ev_valid) begin
              // A zero-velocity note-on is a release with velocity 0.
              lat_on    <= ev_on && (ev_vel != '0);
              lat_key   <= ev_key;
              lat_vel   <= ev_vel;
              scan_idx  <= '0;
              match_hit <= 1'b0;
              free_hit  <= 1'b0;
              state     <= SCAN;
            end
          end
          SCAN: begin
            if (!match_hit && keys_on[scan_idx] && (key_tab[scan_idx] == lat_key)) begin
              match_hit <= 1'b1;
              match_idx <= scan_idx;
            end
            if (!free_hit && !keys_on[scan_idx] && voice_free[scan_idx]) begin
              free_hit <= 1'b1;
              free_idx <= scan_idx;
            end
            if (scan_idx == LAST) begin
              state <= COMMIT;
            end else begin
              scan_idx <= scan_idx + 1'b1;
            end
          end
          COMMIT: begin
            state <= IDLE;
            if (lat_on) begin
              keys_on[on_target] <= 1'b1;
              key_tab[on_target] <= lat_key;
              cur_key_adr        <= on_target;
              cur_key_val        <= {1'b0, lat_key};
              cur_vel_on         <= lat_vel;
              note_on            <= 1'b1;
              steal              <= on_steal;
              if (on_steal) begin
                steal_ptr <= (steal_ptr == LAST) ? '0 : steal_ptr + 1'b1;
              end
            end else if (match_hit) begin
              keys_on[match_idx] <= 1'b0;
              cur_key_adr        <= match_idx;
              cur_vel_off        <= lat_vel;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_voice_alloc.sv
// Bench for voice_alloc: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against an event-level model.
module tb_voice_alloc;

  localparam int VOICES  = 8;
  localparam int V_WIDTH = 3;

  logic               OSC_CLK = 1'b0;
  logic               iRST_N  = 1'b0;
  logic               ev_valid = 1'b0;
  logic               ev_ready;
  logic               ev_on = 1'b0;
  logic [6:0]         ev_key = '0;
  logic [7:0]         ev_vel = '0;
  logic               all_off = 1'b0;
  logic [VOICES-1:0]  voice_free = '1;
  logic [VOICES-1:0]  keys_on;
  logic               note_on;
  logic [V_WIDTH-1:0] cur_key_adr;
  logic [7:0]         cur_key_val;
  logic [7:0]         cur_vel_on;
  logic [7:0]         cur_vel_off;
  logic               steal;

  voice_alloc #(.VOICES(VOICES), .V_WIDTH(V_WIDTH)) dut (
    .OSC_CLK     (OSC_CLK),
    .iRST_N      (iRST_N),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .ev_on       (ev_on),
    .ev_key      (ev_key),
    .ev_vel      (ev_vel),
    .all_off     (all_off),
    .voice_free  (voice_free),
    .keys_on     (keys_on),
    .note_on     (note_on),
    .cur_key_adr (cur_key_adr),
    .cur_key_val (cur_key_val),
    .cur_vel_on  (cur_vel_on),
    .cur_vel_off (cur_vel_off),
    .steal       (steal)
  );

  always #5 OSC_CLK = ~OSC_CLK;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Event-level reference: an event occupies the block for VOICES+1 edges after
  // accept; voice i's idle flag is taken from the edge at which it is scanned.
  logic [VOICES-1:0] m_keys_on;
  logic [6:0]        m_key [VOICES];
  int                m_ptr;
  bit                m_busy;
  int                m_cnt;
  bit                m_on;
  logic [6:0]        m_k;
  logic [7:0]        m_v;
  logic [VOICES-1:0] m_vf;
  bit                m_note_on, m_steal;
  int                m_adr;
  logic [7:0]        m_kval, m_von, m_voff;

  always @(posedge OSC_CLK or negedge iRST_N) begin
    int v;
    bit st;
    if (!iRST_N) begin
      m_keys_on = '0;
      for (int i = 0; i < VOICES; i++) m_key[i] = '0;
      m_ptr = 0; m_busy = 0; m_cnt = 0;
      m_note_on = 0; m_steal = 0;
      m_adr = 0; m_kval = 0; m_von = 0; m_voff = 0;
    end else begin
      m_note_on = 0;
      m_steal   = 0;
      if (all_off) begin
        m_keys_on = '0;
        m_busy    = 0;
      end else if (m_busy) begin
        m_cnt++;
        if (m_cnt <= VOICES) begin
          m_vf[m_cnt-1] = voice_free[m_cnt-1];
        end else begin
          m_busy = 0;
          v = -1;
          for (int i = 0; i < VOICES; i++)
            if (v < 0 && m_keys_on[i] && m_key[i] == m_k) v = i;
          if (m_on) begin
            st = 0;
            for (int i = 0; i < VOICES; i++)
              if (v < 0 && !m_keys_on[i] && m_vf[i]) v = i;
            if (v < 0) begin
              v = m_ptr; st = 1; m_ptr = (m_ptr + 1) % VOICES;
            end
            m_keys_on[v] = 1'b1;
            m_key[v]     = m_k;
            m_adr        = v;
            m_kval       = {1'b0, m_k};
            m_von        = m_v;
            m_note_on    = 1;
            m_steal      = st;
          end else if (v >= 0) begin
            m_keys_on[v] = 1'b0;
            m_adr        = v;
            m_voff       = m_v;
          end
        end
      end else if (ev_valid) begin
        m_on   = ev_on && (ev_vel != 0);
        m_k    = ev_key;
        m_v    = ev_vel;
        m_busy = 1;
        m_cnt  = 0;
      end
    end
  end

  always @(negedge OSC_CLK) begin
    if (cmp_en) begin
      check("ev_ready",    32'(ev_ready),    32'(!m_busy));
      check("keys_on",     32'(keys_on),     32'(m_keys_on));
      check("note_on",     32'(note_on),     32'(m_note_on));
      check("steal",       32'(steal),       32'(m_steal));
      check("cur_key_adr", 32'(cur_key_adr), 32'(m_adr));
      check("cur_key_val", 32'(cur_key_val), 32'(m_kval));
      check("cur_vel_on",  32'(cur_vel_on),  32'(m_von));
      check("cur_vel_off", 32'(cur_vel_off), 32'(m_voff));
    end
  end

  // All drivers run 2 time units after the rising edge.
  task automatic step();
    @(posedge OSC_CLK); #2;
  endtask

  task automatic do_reset();
    iRST_N = 1'b0; all_off = 1'b0; ev_valid = 1'b0; voice_free = '1;
    step(); step();
    iRST_N = 1'b1;
    step();
  endtask

  // Offers one event, then follows it for VOICES+1 edges reporting where note_on rose.
  task automatic send(input bit on, input int key, input int vel,
                      output int on_edge, output bit stl);
    int n = 0;
    while (!ev_ready && n < 40) begin step(); n++; end
    check("ready_wait", 32'(ev_ready), 32'd1);
    ev_valid = 1'b1; ev_on = on; ev_key = 7'(key); ev_vel = 8'(vel);
    step();
    ev_valid = 1'b0;
    on_edge = 0; stl = 1'b0;
    for (int k = 1; k <= VOICES + 1; k++) begin
      @(posedge OSC_CLK); #1;
      if (note_on) begin on_edge = k; stl = steal; end
      #1;
    end
  endtask

  initial begin
    int  e;
    bit  s;
    bit  seen;

    do_reset();
    check("rst_keys_on", 32'(keys_on), 32'h0);
    check("rst_ready",   32'(ev_ready), 32'd1);
    check("rst_key_val", 32'(cur_key_val), 32'd0);
    cmp_en = 1'b1;

    // First note-on lands on voice 0, VOICES+1 edges after accept.
    send(1, 60, 100, e, s);
    check("r37_latency", 32'(e), 32'd9);
    check("r37_adr",     32'(cur_key_adr), 32'd0);
    check("r37_key",     32'(cur_key_val), 32'd60);
    check("r37_vel",     32'(cur_vel_on),  32'd100);
    check("r37_keys_on", 32'(keys_on),     32'h01);

    // Fill all voices, then steal voice 0 and voice 1 in turn.
    do_reset();
    for (int k = 60; k <= 67; k++) send(1, k, 90, e, s);
    check("r38_full", 32'(keys_on), 32'hFF);
    send(1, 70, 90, e, s);
    check("r38_steal0",  32'(s),           32'd1);
    check("r38_adr0",    32'(cur_key_adr), 32'd0);
    check("r38_keys_on", 32'(keys_on),     32'hFF);
    send(1, 71, 90, e, s);
    check("r38_steal1",  32'(s),           32'd1);
    check("r38_adr1",    32'(cur_key_adr), 32'd1);

    // Retrigger, release, unmatched release, zero-velocity release.
    do_reset();
    send(1, 60, 100, e, s);
    send(1, 60, 50, e, s);
    check("r39_adr",   32'(cur_key_adr), 32'd0);
    check("r39_steal", 32'(s),           32'd0);
    check("r39_vel",   32'(cur_vel_on),  32'd50);
    check("r39_keys",  32'(keys_on),     32'h01);
    send(0, 60, 40, e, s);
    check("r40_keys",    32'(keys_on),     32'h00);
    check("r40_vel_off", 32'(cur_vel_off), 32'd40);
    check("r40_no_on",   32'(e),           32'd0);
    send(0, 99, 77, e, s);
    check("r40_nm_vel",  32'(cur_vel_off), 32'd40);
    check("r40_nm_keys", 32'(keys_on),     32'h00);
    send(1, 64, 100, e, s);
    send(1, 64, 0, e, s);
    check("r41_keys",    32'(keys_on),     32'h00);
    check("r41_vel_off", 32'(cur_vel_off), 32'd0);
    check("r41_no_on",   32'(e),           32'd0);

    // Panic during a note-on scan.
    send(1, 62, 100, e, s);
    ev_valid = 1'b1; ev_on = 1'b1; ev_key = 7'd61; ev_vel = 8'd80;
    step();
    ev_valid = 1'b0;
    step(); step(); step();
    all_off = 1'b1;
    step();
    all_off = 1'b0;
    check("r42_keys",  32'(keys_on),  32'h00);
    check("r42_ready", 32'(ev_ready), 32'd1);
    seen = 1'b0;
    for (int k = 0; k < VOICES + 2; k++) begin
      @(posedge OSC_CLK); #1; if (note_on) seen = 1'b1; #1;
    end
    check("r42_no_on", 32'(seen), 32'd0);

    // Reset in the middle of a scan aborts the event.
    send(1, 63, 100, e, s);
    ev_valid = 1'b1; ev_on = 1'b1; ev_key = 7'd65; ev_vel = 8'd80;
    step();
    ev_valid = 1'b0;
    step(); step(); step();
    iRST_N = 1'b0;
    #1;
    check("rst_mid_keys", 32'(keys_on), 32'h00);
    step();
    iRST_N = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < VOICES + 2; k++) begin
      @(posedge OSC_CLK); #1; if (note_on) seen = 1'b1; #1;
    end
    check("rst_mid_no_on", 32'(seen), 32'd0);

    // Random traffic, narrow key range so retriggers, releases and steals all occur.
    for (int c = 0; c < 4000; c++) begin
      ev_valid   = ($urandom_range(0, 2) == 0);
      ev_on      = ($urandom_range(0, 2) != 0);
      ev_key     = 7'(60 + $urandom_range(0, 9));
      ev_vel     = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      voice_free = VOICES'($urandom);
      all_off    = ($urandom_range(0, 199) == 0);
      iRST_N     = ($urandom_range(0, 599) != 0);
      step();
    end
    ev_valid = 1'b0; all_off = 1'b0; iRST_N = 1'b1;
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/voice_alloc.md
VOICE_ALLOC -- requirements
Module: voice_alloc

Interface
REQ-001 Parameter VOICES, default 8, number of synth voices.
REQ-002 Parameter V_WIDTH, default 3, voice index width; SHALL equal clog2(VOICES).
REQ-003 OSC_CLK  in  1  single clock; all state changes on rising edge.
REQ-004 iRST_N  in  1  reset, asynchronous, active-low.
REQ-005 ev_valid  in  1  note event offered.
REQ-006 ev_ready  out  1  block can accept an event.
REQ-007 ev_on  in  1  1 = note-on, 0 = note-off.
REQ-008 ev_key  in  7  MIDI key number.
REQ-009 ev_vel  in  8  velocity.
REQ-010 all_off  in  1  panic: release every voice.
REQ-011 voice_free  in  VOICES  per-voice idle flag from envelope generators.
REQ-012 keys_on  out  VOICES  per-voice gate.
REQ-013 note_on  out  1  one-cycle pulse: voice (re)assigned.
REQ-014 cur_key_adr  out  V_WIDTH  voice index of the last commit.
REQ-015 cur_key_val  out  8  key of the last commit, zero-extended.
REQ-016 cur_vel_on  out  8  note-on velocity of the last on-commit.
REQ-017 cur_vel_off  out  8  release velocity of the last off-commit.
REQ-018 steal  out  1  one-cycle pulse alongside note_on when a busy voice was stolen.

Function
REQ-019 FSM states SHALL be IDLE, SCAN, COMMIT; ev_ready = 1 only in IDLE.
REQ-020 Accept = ev_valid & ev_ready at an edge: latch ev_on, ev_key, ev_vel; clear scan index; go to SCAN.
REQ-021 A note-on with ev_vel = 0 SHALL be handled as a note-off with cur_vel_off = 0.
REQ-022 SCAN SHALL examine one voice per cycle, index 0 to VOICES-1, then go to COMMIT, so a commit occurs VOICES+1 edges after accept.
REQ-023 Per-voice key table SHALL hold the 7-bit key of each gated voice.
REQ-024 Note-on selection priority: (1) lowest-index voice with keys_on = 1 and matching key (retrigger); (2) lowest-index voice with keys_on = 0 and voice_free = 1; (3) voice at steal_ptr.
REQ-025 Note-on commit: set keys_on[v] = 1; write key table; drive cur_key_adr = v, cur_key_val, cur_vel_on; pulse note_on; pulse steal only for case (3).
REQ-026 steal_ptr SHALL increment modulo VOICES after each steal only.
REQ-027 Note-off selection: lowest-index voice with keys_on = 1 and matching key.
REQ-028 Note-off commit with a match: clear keys_on[v]; drive cur_key_adr = v and cur_vel_off; no note_on pulse.
REQ-029 Note-off with no match SHALL change no outputs.
REQ-030 COMMIT lasts one cycle and returns to IDLE; back-to-back accepts are therefore spaced VOICES+2 edges apart.
REQ-031 voice_free SHALL be sampled during SCAN only; changes after a voice's scan cycle do not affect the current event.
REQ-032 all_off at any edge, in any state, SHALL clear keys_on and go to IDLE, dropping any in-flight event.
REQ-033 all_off SHALL take priority over a same-edge commit or accept; note_on and steal stay 0 on that edge.
REQ-034 When all_off is held, ev_ready stays 1 but accepts are ignored.

Reset
REQ-035 While iRST_N = 0:
- keys_on, note_on, steal, cur_key_adr, cur_key_val, cur_vel_on, cur_vel_off, key table, steal_ptr = 0
- state = IDLE, ev_ready = 1
REQ-036 Reset asserted mid-SCAN or mid-COMMIT SHALL abort the event with no commit.

Verification
REQ-037 After reset, all voice_free = 1, note-on key 60 vel 100 -> 9 edges later note_on = 1 for one cycle; cur_key_adr = 0, cur_key_val = 60, cur_vel_on = 100, keys_on = 0x01.
REQ-038 Eight note-ons with keys 60..67, then key 70 -> steal = 1, cur_key_adr = 0, keys_on = 0xFF; a further key 71 steals voice 1.
REQ-039 Voice 0 holds key 60, then note-on key 60 vel 50 -> retrigger voice 0, steal = 0, cur_vel_on = 50.
REQ-040 Note-off key 60 vel 40 while voice 0 holds it -> keys_on[0] = 0, cur_vel_off = 40, note_on stays 0; note-off key 99 -> no output change.
REQ-041 Note-on key 64 vel 0 -> handled as note-off, cur_vel_off = 0.
REQ-042 all_off asserted during SCAN of a note-on -> keys_on = 0, no note_on pulse, ev_ready = 1 on the next cycle.
